// File: rtl/freq_scan_256.sv
// rtl/freq_scan_256.sv - scans the 4-lane frequency RAM and streams non-zero (symbol, frequency) pairs
module freq_scan_256 (
  input  logic        clk,
  input  logic        rstN,
  input  logic        start,
  input  logic        ram_busy,
  output logic        freq_oe,
  output logic [7:0]  freq_addr1a,
  output logic [7:0]  freq_addr2a,
  output logic [7:0]  freq_addr3a,
  output logic [7:0]  freq_addr4a,
  output logic [7:0]  freq_addr1b,
  output logic [7:0]  freq_addr2b,
  output logic [7:0]  freq_addr3b,
  output logic [7:0]  freq_addr4b,
  input  logic [17:0] freq_value1a,
  input  logic [17:0] freq_value2a,
  input  logic [17:0] freq_value3a,
  input  logic [17:0] freq_value4a,
  input  logic [17:0] freq_value1b,
  input  logic [17:0] freq_value2b,
  input  logic [17:0] freq_value3b,
  input  logic [17:0] freq_value4b,
  input  logic        freq_valid,
  output logic [7:0]  out_sym,
  output logic [19:0] out_freq,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic [8:0]  sym_cnt,
  output logic [27:0] total_freq
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t      state;
  logic [7:0]  idx;        // next even index to issue
  logic [7:0]  rd_idx;     // even index of the pair whose data is on freq_value*

  // 8-entry FIFO of {symbol, frequency}
  logic [27:0] fifo_mem [8];
  logic [2:0]  wr_ptr;
  logic [2:0]  rd_ptr;
  logic [3:0]  fifo_cnt;

  logic [19:0] sum_a;
  logic [19:0] sum_b;
  logic        cap_en;
  logic        wr_a;
  logic        wr_b;
  logic [1:0]  wr_num;
  logic        rd_en;
  logic [3:0]  cnt_next;
  logic [1:0]  inflight;
  logic        credit_ok;
  logic        start_ok;
  logic        scan_issue;
  logic        issue;
  logic [7:0]  iss_idx;
  logic [7:0]  iss_idx_odd;
  logic        drain_done;
  logic [2:0]  wr_ptr_b;
  logic [7:0]  rd_idx_odd;
  logic [27:0] fifo_head;
  logic [19:0] add_a;
  logic [19:0] add_b;

  // Lane sums, FIFO bookkeeping and issue decision
  always_comb begin
    sum_a = {2'b00, freq_value1a} + {2'b00, freq_value2a}
          + {2'b00, freq_value3a} + {2'b00, freq_value4a};
    sum_b = {2'b00, freq_value1b} + {2'b00, freq_value2b}
          + {2'b00, freq_value3b} + {2'b00, freq_value4b};

    // Only data belonging to an active scan is captured; stray valids are ignored
    cap_en = freq_valid && ((state == ST_SCAN) || (state == ST_DRAIN));
    wr_a   = cap_en && (sum_a != 20'd0);
    wr_b   = cap_en && (sum_b != 20'd0);
    wr_num = {1'b0, wr_a} + {1'b0, wr_b};
    add_a  = wr_a ? sum_a : 20'd0;
    add_b  = wr_b ? sum_b : 20'd0;

    out_valid = (fifo_cnt != 4'd0);
    rd_en     = out_valid && out_ready;
    cnt_next  = fifo_cnt + {2'b00, wr_num} - {3'b000, rd_en};

    // Each in-flight read can land up to two entries; reserve room for them
    inflight  = {1'b0, freq_oe} + {1'b0, freq_valid};
    credit_ok = ({1'b0, fifo_cnt} + {2'b00, inflight, 1'b0}) <= 5'd4;

    start_ok    = (state == ST_IDLE) && start && !ram_busy;
    scan_issue  = (state == ST_SCAN) && !ram_busy && credit_ok;
    issue       = start_ok || scan_issue;
    iss_idx     = start_ok ? 8'd0 : idx;
    iss_idx_odd = {iss_idx[7:1], 1'b1};

    // Drain ends at the edge that leaves the FIFO empty with nothing outstanding
    drain_done = (state == ST_DRAIN) && !freq_oe && (cnt_next == 4'd0);

    // When only symB is written it takes the slot at wr_ptr
    wr_ptr_b   = wr_a ? (wr_ptr + 3'd1) : wr_ptr;
    rd_idx_odd = {rd_idx[7:1], 1'b1};

    fifo_head = fifo_mem[rd_ptr];
    out_sym   = out_valid ? fifo_head[27:20] : 8'd0;
    out_freq  = out_valid ? fifo_head[19:0]  : 20'd0;
  end

  // Scan FSM with registered read request, addresses, busy and done
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state       <= ST_IDLE;
      idx         <= 8'd0;
      freq_oe     <= 1'b0;
      freq_addr1a <= 8'd0;
      freq_addr2a <= 8'd0;
      freq_addr3a <= 8'd0;
      freq_addr4a <= 8'd0;
      freq_addr1b <= 8'd0;
      freq_addr2b <= 8'd0;
      freq_addr3b <= 8'd0;
      freq_addr4b <= 8'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      freq_oe <= issue;
      done    <= 1'b0;
      if (issue) begin
        freq_addr1a <= iss_idx;
        freq_addr2a <= iss_idx;
        freq_addr3a <= iss_idx;
        freq_addr4a <= iss_idx;
        freq_addr1b <= iss_idx_odd;
        freq_addr2b <= iss_idx_odd;
        freq_addr3b <= iss_idx_odd;
        freq_addr4b <= iss_idx_odd;
        idx         <= iss_idx + 8'd2;
      end
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            state <= ST_SCAN;
            busy  <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (scan_issue && (idx == 8'd254)) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_done) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Remember which pair the RAM is answering for in the following cycle
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rd_idx <= 8'd0;
    end else if (freq_oe) begin
      rd_idx <= freq_addr1a;
    end
  end

  // FIFO storage; symA lands before symB
  always_ff @(posedge clk) begin
    if (wr_a) begin
      fifo_mem[wr_ptr] <= {rd_idx, sum_a};
    end
    if (wr_b) begin
      fifo_mem[wr_ptr_b] <= {rd_idx_odd, sum_b};
    end
  end

  // FIFO pointers and occupancy; reset discards any contents
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr   <= 3'd0;
      rd_ptr   <= 3'd0;
      fifo_cnt <= 4'd0;
    end else begin
      wr_ptr   <= wr_ptr + {1'b0, wr_num};
      rd_ptr   <= rd_ptr + {2'b00, rd_en};
      fifo_cnt <= cnt_next;
    end
  end

  // Symbol count and byte total, cleared on an accepted start and held afterwards
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sym_cnt    <= 9'd0;
      total_freq <= 28'd0;
    end else if (start_ok) begin
      sym_cnt    <= 9'd0;
      total_freq <= 28'd0;
    end else if (cap_en) begin
      sym_cnt    <= sym_cnt + {7'd0, wr_num};
      total_freq <= total_freq + {8'd0, add_a} + {8'd0, add_b};
    end
  end

endmodule

// File: tb/tb_freq_scan_256.sv
// tb/tb_freq_scan_256.sv - directed self-checking bench for freq_scan_256
module tb_freq_scan_256;

  logic        clk = 1'b0;
  logic        rstN;
  logic        start;
  logic        ram_busy;
  logic        freq_oe;
  logic [7:0]  freq_addr1a, freq_addr2a, freq_addr3a, freq_addr4a;
  logic [7:0]  freq_addr1b, freq_addr2b, freq_addr3b, freq_addr4b;
  logic [17:0] freq_value1a = '0, freq_value2a = '0, freq_value3a = '0, freq_value4a = '0;
  logic [17:0] freq_value1b = '0, freq_value2b = '0, freq_value3b = '0, freq_value4b = '0;
  logic        freq_valid = 1'b0;
  logic [7:0]  out_sym;
  logic [19:0] out_freq;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic [8:0]  sym_cnt;
  logic [27:0] total_freq;

  always #5 clk = ~clk;

  freq_scan_256 dut (
    .clk(clk), .rstN(rstN), .start(start), .ram_busy(ram_busy), .freq_oe(freq_oe),
    .freq_addr1a(freq_addr1a), .freq_addr2a(freq_addr2a),
    .freq_addr3a(freq_addr3a), .freq_addr4a(freq_addr4a),
    .freq_addr1b(freq_addr1b), .freq_addr2b(freq_addr2b),
    .freq_addr3b(freq_addr3b), .freq_addr4b(freq_addr4b),
    .freq_value1a(freq_value1a), .freq_value2a(freq_value2a),
    .freq_value3a(freq_value3a), .freq_value4a(freq_value4a),
    .freq_value1b(freq_value1b), .freq_value2b(freq_value2b),
    .freq_value3b(freq_value3b), .freq_value4b(freq_value4b),
    .freq_valid(freq_valid), .out_sym(out_sym), .out_freq(out_freq),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done),
    .sym_cnt(sym_cnt), .total_freq(total_freq)
  );

  // Statistics RAM model: one-cycle read latency
  logic [17:0] ram [4][256];
  always @(posedge clk) begin
    freq_valid <= freq_oe;
    if (freq_oe) begin
      freq_value1a <= ram[0][freq_addr1a];
      freq_value2a <= ram[1][freq_addr2a];
      freq_value3a <= ram[2][freq_addr3a];
      freq_value4a <= ram[3][freq_addr4a];
      freq_value1b <= ram[0][freq_addr1b];
      freq_value2b <= ram[1][freq_addr2b];
      freq_value3b <= ram[2][freq_addr3b];
      freq_value4b <= ram[3][freq_addr4b];
    end
  end

  // FIFO must never be written beyond its 8 entries
  int ovf_cnt = 0;
  always @(negedge clk) begin
    if (rstN === 1'b1) begin
      assert (int'(dut.fifo_cnt) + int'(dut.wr_num) - int'(dut.rd_en) <= 8)
      else ovf_cnt++;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  logic [7:0]  exp_sym  [256];
  logic [19:0] exp_freq [256];
  int          exp_n;
  int          rx_k, oe_cnt, oe_run, oe_max, done_cnt, max_occ;
  logic [7:0]  next_addr;

  task automatic clear_ram();
    for (int l = 0; l < 4; l++)
      for (int s = 0; s < 256; s++)
        ram[l][s] = 18'd0;
    exp_n = 0;
  endtask

  task automatic fill_nonzero();
    logic [19:0] f;
    clear_ram();
    for (int s = 0; s < 256; s++) begin
      ram[0][s] = 18'(s + 1);
      ram[1][s] = 18'((s * 3) & 255);
      ram[3][s] = 18'(s ^ 8'hA5);
      f = 20'(ram[0][s]) + 20'(ram[1][s]) + 20'(ram[2][s]) + 20'(ram[3][s]);
      exp_sym[exp_n]  = 8'(s);
      exp_freq[exp_n] = f;
      exp_n++;
    end
  endtask

  function automatic logic [27:0] exp_total();
    logic [27:0] t = 28'd0;
    for (int i = 0; i < exp_n; i++) t += 28'(exp_freq[i]);
    return t;
  endfunction

  task automatic check_reset_state();
    check("rst_ctrl", {freq_oe, out_valid, busy, done}, 4'h0);
    check("rst_addr", {freq_addr1a, freq_addr2a, freq_addr3a, freq_addr4a,
                       freq_addr1b, freq_addr2b, freq_addr3b, freq_addr4b}, 64'd0);
    check("rst_out", {out_sym, out_freq}, 28'd0);
    check("rst_acc", {sym_cnt, total_freq}, 37'd0);
  endtask

  // Per-cycle observation at the negedge: transfers, issued addresses, done
  task automatic sample();
    logic [7:0] na1;
    na1 = {next_addr[7:1], 1'b1};
    if (out_valid && out_ready) begin
      if (rx_k < exp_n) begin
        check("out_sym", out_sym, exp_sym[rx_k]);
        check("out_freq", out_freq, exp_freq[rx_k]);
      end else begin
        check("xfer_overrun", rx_k + 1, exp_n);
      end
      rx_k++;
    end
    if (freq_oe) begin
      check("issue_addr", {freq_addr1a, freq_addr2a, freq_addr3a, freq_addr4a,
                           freq_addr1b, freq_addr2b, freq_addr3b, freq_addr4b},
            {next_addr, next_addr, next_addr, next_addr, na1, na1, na1, na1});
      next_addr += 8'd2;
      oe_cnt++;
      oe_run++;
      if (oe_run > oe_max) oe_max = oe_run;
    end else begin
      oe_run = 0;
    end
    if (done) begin
      done_cnt++;
      check("busy_at_done", busy, 1'b0);
    end
    if (int'(dut.fifo_cnt) > max_occ) max_occ = int'(dut.fifo_cnt);
  endtask

  task automatic run(input string name, input int exp_sc, input logic [27:0] exp_tot,
                     input bit lat, input int stall_at, input int busy_at,
                     input int abort_at, input bit zero_run);
    int cyc;
    int done_at;
    rx_k = 0; oe_cnt = 0; oe_run = 0; oe_max = 0; done_cnt = 0; max_occ = 0;
    next_addr = 8'd0; done_at = -1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (cyc < 6000 && (done_at < 0 || cyc <= done_at + 3)) begin
      @(negedge clk);
      sample();
      if (done && done_at < 0) done_at = cyc;
      if (lat) begin
        if (cyc == 0) check("lat_c0_busy_oe", {busy, freq_oe, out_valid}, 3'b110);
        if (cyc == 1) check("lat_c1_valid", out_valid, 1'b0);
        if (cyc == 2) check("lat_c2_sym0", {out_valid, out_sym, out_freq}, {1'b1, 8'd0, 20'd1});
      end
      if (stall_at >= 0 && cyc == stall_at + 30) begin
        check("stall_oe_stopped", freq_oe, 1'b0);
        check("stall_head", {out_valid, out_sym}, {1'b1, exp_sym[rx_k]});
        check("stall_occ_le_8", max_occ > 8, 1'b0);
      end
      if (busy_at >= 0 && cyc >= busy_at + 2 && cyc <= busy_at + 11)
        check("oe_in_ram_busy", freq_oe, 1'b0);
      @(posedge clk);
      #1;
      if (stall_at >= 0 && cyc == stall_at) out_ready = 1'b0;
      if (stall_at >= 0 && cyc == stall_at + 30) out_ready = 1'b1;
      if (busy_at >= 0 && cyc == busy_at) ram_busy = 1'b1;
      if (busy_at >= 0 && cyc == busy_at + 10) ram_busy = 1'b0;
      start = (busy_at >= 0 && cyc == busy_at + 15);
      if (abort_at >= 0 && cyc == abort_at) begin
        rstN = 1'b0;
        #1 check_reset_state();
        break;
      end
      cyc++;
    end
    if (abort_at >= 0) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("abort_no_done", done, 1'b0);
      end
      check_reset_state();
      check("abort_done_cnt", done_cnt, 0);
      @(posedge clk);
      #1 rstN = 1'b1;
    end else begin
      check({name, "_done_pulse"}, done_cnt, 1);
      check({name, "_xfers"}, rx_k, exp_n);
      check({name, "_sym_cnt"}, sym_cnt, exp_sc);
      check({name, "_total"}, total_freq, exp_tot);
      check({name, "_oe_cycles"}, oe_cnt, 128);
      if (zero_run) check({name, "_oe_run"}, oe_max, 128);
    end
  endtask

  initial begin
    rstN = 1'b0; start = 1'b0; ram_busy = 1'b0; out_ready = 1'b1;
    clear_ram();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state();
    @(posedge clk);
    #1 rstN = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // all counts zero
    clear_ram();
    run("zero", 0, 28'd0, 1'b0, -1, -1, -1, 1'b1);

    // single symbol 0x41 with lanes 3/0/5/1
    clear_ram();
    ram[0][8'h41] = 18'd3; ram[2][8'h41] = 18'd5; ram[3][8'h41] = 18'd1;
    exp_sym[0] = 8'h41; exp_freq[0] = 20'd9; exp_n = 1;
    run("sym41", 1, 28'd9, 1'b0, -1, -1, -1, 1'b0);

    // every symbol count 1 in lane 1
    clear_ram();
    for (int s = 0; s < 256; s++) begin
      ram[0][s] = 18'd1;
      exp_sym[s] = 8'(s); exp_freq[s] = 20'd1;
    end
    exp_n = 256;
    run("ones", 256, 28'd256, 1'b1, -1, -1, -1, 1'b0);

    // boundary: 0xFE at maximum lane counts, 0xFF lanes 1
    clear_ram();
    for (int l = 0; l < 4; l++) begin
      ram[l][8'hFE] = 18'h3FFFF;
      ram[l][8'hFF] = 18'd1;
    end
    exp_sym[0] = 8'hFE; exp_freq[0] = 20'hFFFFC;
    exp_sym[1] = 8'hFF; exp_freq[1] = 20'd4;
    exp_n = 2;
    run("top", 2, 28'h100000, 1'b0, -1, -1, -1, 1'b0);

    // all symbols non-zero, consumer stalls 30 cycles mid-scan
    fill_nonzero();
    run("stall", 256, exp_total(), 1'b0, 20, -1, -1, 1'b0);

    // ram_busy for 10 cycles mid-scan plus a start pulse while busy
    fill_nonzero();
    run("rambusy", 256, exp_total(), 1'b0, -1, 25, -1, 1'b0);

    // reset mid-scan, then a full scan
    fill_nonzero();
    run("abort", 0, 28'd0, 1'b0, -1, -1, 40, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    run("after_abort", 256, exp_total(), 1'b0, -1, -1, -1, 1'b0);

    check("fifo_overflow", ovf_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
